// File: rtl/image_input_seq.sv
// Frame sequencer: reads one IMG_W x IMG_H image from pixel memory in raster order and streams it
// to the line-buffer/conv stage, tagging pixels that complete a KERNEL x KERNEL window.
module image_input_seq #(
   parameter int IMG_W    = 28,
   parameter int IMG_H    = 28,
   parameter int CHANNELS = 3,
   parameter int DATA_W   = 8,
   parameter int KERNEL   = 3,
   parameter int ADDR_W   = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         conv_start,
   input  logic                         out_ready,
   output logic                         mem_rd_en,
   output logic [ADDR_W-1:0]            mem_rd_addr,
   input  logic [CHANNELS*DATA_W-1:0]   mem_rd_data,
   output logic [CHANNELS*DATA_W-1:0]   pix_data,
   output logic                         pix_valid,
   output logic                         pix_last,
   output logic                         window_valid,
   output logic                         window_ready,
   output logic                         busy,
   output logic                         frame_done
);

   // state  | meaning
   // IDLE   | waiting for conv_start
   // PREP   | one-cycle memory setup slot
   // STREAM | one read per cycle while out_ready is high
   // DRAIN  | last pixel returning; frame_done pulse
   typedef enum logic [1:0] {IDLE, PREP, STREAM, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(KERNEL - 1);

   state_t            state, state_next;
   logic [ADDR_W-1:0] row, col, addr;
   logic [ADDR_W-1:0] row_q, col_q;
   logic              pix_valid_q;
   logic              window_ready_q;
   logic              start_accept;
   logic              rd_last;
   logic              win_pos;

   assign rd_last = (row == ROW_LAST) && (col == COL_LAST);

   always_comb begin
      state_next   = state;
      mem_rd_en    = 1'b0;
      start_accept = 1'b0;
      frame_done   = 1'b0;
      case (state)
         IDLE: begin
            if (conv_start) begin
               start_accept = 1'b1;
               state_next   = PREP;
            end
         end
         PREP: state_next = STREAM;
         STREAM: begin
            mem_rd_en = out_ready;
            if (out_ready && rd_last) state_next = DRAIN;
         end
         DRAIN: begin
            frame_done = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         row   <= '0;
         col   <= '0;
         addr  <= '0;
      end else begin
         state <= state_next;
         if (start_accept) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
         end else if (mem_rd_en) begin
            // Counters return to zero after the final read so the next frame starts clean.
            if (rd_last) begin
               row  <= '0;
               col  <= '0;
               addr <= '0;
            end else if (col == COL_LAST) begin
               col  <= '0;
               row  <= row + 1'b1;
               addr <= addr + 1'b1;
            end else begin
               col  <= col + 1'b1;
               addr <= addr + 1'b1;
            end
         end
      end
   end

   // Return path: position tag travels one cycle behind the read, matching memory latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_valid_q    <= 1'b0;
         row_q          <= '0;
         col_q          <= '0;
         window_ready_q <= 1'b0;
      end else begin
         pix_valid_q <= mem_rd_en;
         if (mem_rd_en) begin
            row_q <= row;
            col_q <= col;
         end
         if (window_valid) window_ready_q <= 1'b1;
         if (start_accept) window_ready_q <= 1'b0;
      end
   end

   generate
      if (KERNEL == 1) begin : g_k1
         assign win_pos = 1'b1;
      end else begin : g_kn
         assign win_pos = (row_q >= K_LAST) && (col_q >= K_LAST);
      end
   endgenerate

   assign mem_rd_addr  = addr;
   assign pix_data     = mem_rd_data;
   assign pix_valid    = pix_valid_q;
   assign pix_last     = pix_valid_q && (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign window_valid = pix_valid_q && win_pos;
   // Flag follows the pixel in the same cycle and drops as soon as a new start is accepted.
   assign window_ready = (window_ready_q && !start_accept) || window_valid;
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_image_input_seq.sv
// Self-checking bench for image_input_seq: default 28x28/K3, small 4x3/K3 and 28x28/K1 instances.
module tb_image_input_seq;
   localparam int N  = 784;
   localparam int DW = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic out_ready = 1'b1;
   logic start_m = 1'b0, start_s = 1'b0, start_k = 1'b0;

   logic          m_rd_en, m_pix_valid, m_pix_last, m_win_valid, m_win_ready, m_busy, m_fd;
   logic [9:0]    m_addr;
   logic [DW-1:0] m_rd_data, m_pix_data;
   logic          s_rd_en, s_pix_valid, s_pix_last, s_win_valid, s_win_ready, s_busy, s_fd;
   logic [9:0]    s_addr;
   logic [DW-1:0] s_rd_data, s_pix_data;
   logic          k_rd_en, k_pix_valid, k_pix_last, k_win_valid, k_win_ready, k_busy, k_fd;
   logic [9:0]    k_addr;
   logic [DW-1:0] k_rd_data, k_pix_data;

   image_input_seq dut (
      .clk(clk), .rst(rst), .conv_start(start_m), .out_ready(out_ready),
      .mem_rd_en(m_rd_en), .mem_rd_addr(m_addr), .mem_rd_data(m_rd_data),
      .pix_data(m_pix_data), .pix_valid(m_pix_valid), .pix_last(m_pix_last),
      .window_valid(m_win_valid), .window_ready(m_win_ready), .busy(m_busy), .frame_done(m_fd));

   image_input_seq #(.IMG_W(4), .IMG_H(3), .KERNEL(3)) dut_s (
      .clk(clk), .rst(rst), .conv_start(start_s), .out_ready(out_ready),
      .mem_rd_en(s_rd_en), .mem_rd_addr(s_addr), .mem_rd_data(s_rd_data),
      .pix_data(s_pix_data), .pix_valid(s_pix_valid), .pix_last(s_pix_last),
      .window_valid(s_win_valid), .window_ready(s_win_ready), .busy(s_busy), .frame_done(s_fd));

   image_input_seq #(.KERNEL(1)) dut_k (
      .clk(clk), .rst(rst), .conv_start(start_k), .out_ready(out_ready),
      .mem_rd_en(k_rd_en), .mem_rd_addr(k_addr), .mem_rd_data(k_rd_data),
      .pix_data(k_pix_data), .pix_valid(k_pix_valid), .pix_last(k_pix_last),
      .window_valid(k_win_valid), .window_ready(k_win_ready), .busy(k_busy), .frame_done(k_fd));

   function automatic logic [DW-1:0] mem_word(input logic [9:0] a);
      return {a[7:0] ^ 8'hA5, {6'b0, a[9:8]} ^ 8'h3C, a[7:0] + 8'd17};
   endfunction

   function automatic bit win_exp(input int idx, input int w, input int k);
      return ((idx / w) >= k - 1) && ((idx % w) >= k - 1);
   endfunction

   always @(posedge clk) if (m_rd_en) m_rd_data <= mem_word(m_addr);
   always @(posedge clk) if (s_rd_en) s_rd_data <= mem_word(s_addr);
   always @(posedge clk) if (k_rd_en) k_rd_data <= mem_word(k_addr);

   int errors = 0, checks = 0;
   int rel = 0;
   bit tog = 1'b0;
   int exp_q[$];
   int exp_rd, first_rd, first_pix, last_pix_rel, fd_rel, fd_cnt, pix_cnt, win_cnt, first_win;
   int s_idx, s_win;
   int k_pix, k_win;

   task automatic step();
      int idx;
      @(negedge clk);
      rel++;
      start_m = 1'b0; start_s = 1'b0; start_k = 1'b0;
      out_ready = tog ? rel[0] : 1'b1;
      #1;
      if (m_rd_en) begin
         checks++;
         if (m_addr !== 10'(exp_rd)) begin
            errors++; $display("FAIL rd_addr: got %0d expected %0d (rel %0d)", m_addr, exp_rd, rel);
         end
         if (first_rd < 0) first_rd = rel;
         exp_rd++;
      end
      if (m_pix_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL pix_extra: unexpected pix_valid at rel %0d", rel);
         end else begin
            idx = exp_q.pop_front();
            checks++;
            if (m_pix_data !== mem_word(10'(idx))) begin
               errors++; $display("FAIL pix_data: got %h expected %h (idx %0d)", m_pix_data, mem_word(10'(idx)), idx);
            end
            checks++;
            if (m_pix_last !== (idx == N - 1)) begin
               errors++; $display("FAIL pix_last: got %b expected %b (idx %0d)", m_pix_last, (idx == N - 1), idx);
            end
            checks++;
            if (m_win_valid !== win_exp(idx, 28, 3)) begin
               errors++; $display("FAIL window_valid: got %b expected %b (idx %0d)", m_win_valid, win_exp(idx, 28, 3), idx);
            end
            if (m_win_valid && first_win < 0) first_win = idx;
            if (m_win_valid) win_cnt++;
            if (first_pix < 0) first_pix = rel;
            if (m_pix_last) last_pix_rel = rel;
            pix_cnt++;
         end
      end
      if (m_fd) begin fd_cnt++; fd_rel = rel; end
      if (s_pix_valid) begin
         checks++;
         if (s_win_valid !== (s_idx == 10 || s_idx == 11) || s_pix_last !== (s_idx == 11) ||
             s_win_ready !== (s_idx >= 10) || s_pix_data !== mem_word(10'(s_idx))) begin
            errors++;
            $display("FAIL small_pix: idx %0d got win=%b last=%b ready=%b data=%h", s_idx, s_win_valid, s_pix_last, s_win_ready, s_pix_data);
         end
         if (s_win_valid) s_win++;
         s_idx++;
      end
      if (k_pix_valid) begin
         checks++;
         if (k_win_valid !== 1'b1 || k_win_ready !== 1'b1) begin
            errors++; $display("FAIL k1_pix: idx %0d got win=%b ready=%b expected 1 1", k_pix, k_win_valid, k_win_ready);
         end
         if (k_win_valid) k_win++;
         k_pix++;
      end
   endtask

   task automatic start_main();
      start_m = 1'b1;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(i);
      exp_rd = 0; first_rd = -1; first_pix = -1; last_pix_rel = -1; fd_rel = -1;
      fd_cnt = 0; pix_cnt = 0; win_cnt = 0; first_win = -1;
      rel = 0;
   endtask

   task automatic wait_main_done(input int bound);
      while (fd_cnt == 0 && rel < bound) step();
      checks++;
      if (fd_cnt == 0) begin
         errors++; $display("FAIL frame_timeout: no frame_done within %0d cycles", bound);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++; $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({m_rd_en, m_addr, m_pix_valid, m_pix_last, m_win_valid, m_win_ready, m_busy, m_fd} !== '0) begin
         errors++; $display("FAIL reset_main: outputs %b expected all 0", {m_rd_en, m_addr, m_pix_valid, m_pix_last, m_win_valid, m_win_ready, m_busy, m_fd});
      end
      checks++;
      if ({s_rd_en, s_addr, s_pix_valid, s_pix_last, s_win_valid, s_win_ready, s_busy, s_fd,
           k_rd_en, k_addr, k_pix_valid, k_pix_last, k_win_valid, k_win_ready, k_busy, k_fd} !== '0) begin
         errors++; $display("FAIL reset_small: small/k1 outputs not all 0");
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_frame_default();
      tog = 1'b0;
      start_main();
      start_k = 1'b1; k_pix = 0; k_win = 0;
      wait_main_done(900);
      check_int("first_rd_en_cycle", first_rd, 2);
      check_int("first_pix_valid_cycle", first_pix, 3);
      check_int("pix_count", pix_cnt, N);
      check_int("window_count", win_cnt, 676);
      check_int("first_window_idx", first_win, 58);
      check_int("pix_last_cycle", last_pix_rel, 786);
      check_int("frame_done_cycle", fd_rel, 786);
      check_int("frame_done_count", fd_cnt, 1);
      step();
      check_int("busy_after_frame", int'(m_busy), 0);
      check_int("k1_pix_count", k_pix, N);
      check_int("k1_window_count", k_win, N);
   endtask

   task automatic test_small_image();
      start_s = 1'b1; s_idx = 0; s_win = 0;
      repeat (20) step();
      check_int("small_pix_count", s_idx, 12);
      check_int("small_window_count", s_win, 2);
      check_int("small_busy_after", int'(s_busy), 0);
   endtask

   task automatic test_stall_toggle();
      tog = 1'b1;
      start_main();
      wait_main_done(2000);
      check_int("stall_read_count", exp_rd, N);
      check_int("stall_pix_count", pix_cnt, N);
      check_int("stall_frame_done_cycle", fd_rel, 1570);
      check_int("stall_pix_last_cycle", last_pix_rel, 1570);
      tog = 1'b0;
      step();
   endtask

   task automatic test_start_while_busy();
      tog = 1'b0;
      start_main();
      while (rel < 786) begin
         step();
         if (rel == 100) start_m = 1'b1;
      end
      check_int("busy_restart_fd_count", fd_cnt, 1);
      check_int("window_ready_sticky", int'(m_win_ready), 1);
      start_m = 1'b1;
      step();
      check_int("drain_start_ignored_busy", int'(m_busy), 0);
      check_int("busy_restart_fd_total", fd_cnt, 1);
      start_main();
      #1;
      check_int("window_ready_cleared", int'(m_win_ready), 0);
      wait_main_done(900);
      check_int("second_frame_done_cycle", fd_rel, 786);
      check_int("second_frame_pix_count", pix_cnt, N);
      step();
   endtask

   task automatic test_reset_mid_frame();
      tog = 1'b0;
      start_main();
      while (rel < 300) step();
      rst = 1'b1;
      step();
      checks++;
      if ({m_rd_en, m_addr, m_pix_valid, m_pix_last, m_win_valid, m_win_ready, m_busy, m_fd} !== '0) begin
         errors++; $display("FAIL midreset_outputs: %b expected all 0", {m_rd_en, m_addr, m_pix_valid, m_pix_last, m_win_valid, m_win_ready, m_busy, m_fd});
      end
      check_int("midreset_no_frame_done", fd_cnt, 0);
      rst = 1'b0;
      exp_q.delete();
      step();
      start_main();
      wait_main_done(900);
      check_int("after_reset_first_rd", first_rd, 2);
      check_int("after_reset_pix_count", pix_cnt, N);
      check_int("after_reset_frame_done_cycle", fd_rel, 786);
      step();
   endtask

   initial begin
      test_reset();
      test_frame_default();
      test_small_image();
      test_stall_toggle();
      test_start_while_busy();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/image_input_seq.md
Name: image_input_seq

Overview:
- Parametrised frame sequencer at the head of the convolution pipeline.
- On a start request it reads one IMG_W x IMG_H image from pixel memory in raster order. Each memory word carries CHANNELS samples.
- Streams pixels to the line-buffer/conv stage, tagging each pixel that completes a full KERNEL x KERNEL window.
- Supports downstream stall, frame-done pulse and a sticky window-ready flag. Generalises the fixed 28x28x3 / 3x3 input counter.

Parameters:
- IMG_W, 28, image width in pixels (>= KERNEL)
- IMG_H, 28, image height in pixels (>= KERNEL)
- CHANNELS, 3, samples per pixel word
- DATA_W, 8, bits per sample
- KERNEL, 3, square kernel side (>= 1)
- ADDR_W, 10, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- conv_start  in  1  frame start request, sampled in IDLE only
- out_ready  in  1  downstream can accept a pixel 1 cycle later; low = stall
- mem_rd_en  out  1  pixel memory read strobe
- mem_rd_addr  out  ADDR_W  raster address, row*IMG_W+col
- mem_rd_data  in  CHANNELS*DATA_W  read data, valid 1 cycle after mem_rd_en
- pix_data  out  CHANNELS*DATA_W  combinational pass-through of mem_rd_data
- pix_valid  out  1  pix_data valid this cycle
- pix_last  out  1  with pix_valid, last pixel of frame
- window_valid  out  1  with pix_valid, pixel completes a KERNEL x KERNEL window
- window_ready  out  1  sticky: at least one window completed this frame
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset:
  - state = IDLE; all counters = 0.
  - mem_rd_en, pix_valid, pix_last, window_valid, window_ready, busy and frame_done = 0.
  - mem_rd_addr = 0.
  - Reset mid-frame aborts the frame immediately, with no frame_done.
- FSM states: IDLE, PREP, STREAM, DRAIN.
  - IDLE -> PREP when conv_start = 1. Clears window_ready and the row/col counters.
  - PREP -> STREAM unconditionally. This is the one-cycle memory setup slot.
  - STREAM: mem_rd_en = out_ready (combinational from state and out_ready). mem_rd_addr = current raster counter.
    - On each read, col increments. At col = IMG_W-1, col wraps to 0 and row increments.
    - The read at row = IMG_H-1, col = IMG_W-1 moves the FSM to DRAIN.
    - out_ready = 0 holds the address and counters, and issues no read.
  - DRAIN -> IDLE after one cycle. frame_done = 1 for exactly that DRAIN cycle.
- Return path:
  - pix_valid is mem_rd_en delayed 1 cycle (registered).
  - A delayed row/col copy travels with it.
  - pix_last = pix_valid and delayed (row, col) = (IMG_H-1, IMG_W-1).
  - window_valid = pix_valid and delayed row >= KERNEL-1 and delayed col >= KERNEL-1.
  - window_ready sets on the first window_valid and holds until the next accepted conv_start or reset.
- Latency:
  - conv_start sampled at cycle T: first mem_rd_en at T+2, first pix_valid at T+3.
  - Unstalled frame: last pix_valid at T+2+IMG_W*IMG_H, with frame_done in the same cycle (DRAIN).
- Counts:
  - Per frame: pix_valid count = IMG_W*IMG_H.
  - window_valid count = (IMG_W-KERNEL+1)*(IMG_H-KERNEL+1).
  - First window_valid at raster index (KERNEL-1)*IMG_W+(KERNEL-1).
- Boundary and simultaneous events:
  - conv_start while busy = 1 is ignored, with no queueing.
  - conv_start in the DRAIN cycle is ignored. It is accepted the following cycle, in IDLE.
  - KERNEL = 1: every pixel is window_valid, and window_ready rises with the first pixel.
  - out_ready may toggle every cycle. Read count and order are unaffected, with no duplicates and no skips.
  - Stall in the final STREAM cycle delays DRAIN until the last read issues.
  - Counter arithmetic stays unsigned within ADDR_W. Row and col never exceed IMG_H-1 and IMG_W-1.

Test Plan:
- Defaults, out_ready = 1, conv_start pulse at cycle 0:
  - mem_rd_en first at cycle 2, pix_valid first at cycle 3.
  - 784 pix_valid, 676 window_valid; first window_valid at pixel index 58.
  - pix_last and frame_done at cycle 786; busy low at cycle 787.
- IMG_W=4, IMG_H=3, KERNEL=3:
  - window_valid only on raster indices 10 and 11.
  - window_ready rises with index 10; pix_last on index 11.
- Defaults, out_ready toggled 1,0,1,0 throughout:
  - Addresses 0..783 issued exactly once, in order.
  - Frame takes 1568 STREAM cycles.
  - pix_data matches the memory model at every pix_valid.
- conv_start reasserted at cycles 100 and 786 during a frame:
  - Both ignored; only one frame_done.
  - A new start at cycle 787 is accepted; window_ready clears at cycle 787.
- rst = 1 at cycle 300 mid-frame:
  - All outputs 0 next cycle, with no frame_done.
  - A following conv_start runs a full frame from address 0.
- KERNEL=1 at default size: 784 window_valid; window_ready high with the first pix_valid.
